// File: rtl/system_alarm_out_pio.sv
// rtl/system_alarm_out_pio.sv - Avalon-MM alarm output PIO with programmable blink and burst engine
// Optional burst-done interrupt enabled by defining SYSTEM_ALARM_OUT_PIO_IRQ_EN.
module system_alarm_out_pio #(
   parameter int unsigned WIDTH       = 5,
   parameter int unsigned RESET_VALUE = 0,
   parameter int unsigned PERIOD_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [WIDTH-1:0]    L_RESET   = WIDTH'(RESET_VALUE);
   localparam logic [PERIOD_W-1:0] L_P_ONE   = PERIOD_W'(1);
   localparam logic [2:0]          A_DATA    = 3'd0;
   localparam logic [2:0]          A_PERIOD  = 3'd1;
   localparam logic [2:0]          A_MASK    = 3'd2;
   localparam logic [2:0]          A_STATUS  = 3'd3;
   localparam logic [2:0]          A_OUTSET  = 3'd4;
   localparam logic [2:0]          A_OUTCLR  = 3'd5;
   localparam logic [2:0]          A_BURST   = 3'd6;
   localparam logic [2:0]          A_IRQMASK = 3'd7;

   logic [WIDTH-1:0]    r_data;
   logic [PERIOD_W-1:0] r_period;
   logic [WIDTH-1:0]    r_mask;
   logic [PERIOD_W-1:0] r_count;
   logic [7:0]          r_burst;
   logic                r_phase;
   logic                r_done;

   logic                w_wr;
   logic                w_wr_data;
   logic                w_wr_period;
   logic                w_wr_mask;
   logic                w_wr_status;
   logic                w_wr_outset;
   logic                w_wr_outclr;
   logic                w_wr_burst;
   logic                w_active;
   logic                w_toggle;
   logic                w_terminal;
   logic [WIDTH-1:0]    w_wd;
   logic [31:0]         w_rdata;
   logic                w_unused;

   assign w_wr        = chipselect & ~write_n;
   assign w_wr_data   = w_wr && (address == A_DATA);
   assign w_wr_period = w_wr && (address == A_PERIOD);
   assign w_wr_mask   = w_wr && (address == A_MASK);
   assign w_wr_status = w_wr && (address == A_STATUS);
   assign w_wr_outset = w_wr && (address == A_OUTSET);
   assign w_wr_outclr = w_wr && (address == A_OUTCLR);
   assign w_wr_burst  = w_wr && (address == A_BURST);
   assign w_wd        = writedata[WIDTH-1:0];
   assign w_unused    = &{1'b0, writedata};

   // A PERIOD write in the same cycle suppresses the toggle entirely, burst count included.
   assign w_active   = (r_period != '0) && (r_mask != '0);
   assign w_toggle   = w_active && (r_count == (r_period - L_P_ONE)) && !w_wr_period;
   assign w_terminal = w_toggle && (r_burst == 8'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= L_RESET;
      end else if (w_wr_data) begin
         r_data <= w_wd;
      end else if (w_wr_outset) begin
         r_data <= r_data | w_wd;
      end else if (w_wr_outclr) begin
         r_data <= r_data & ~w_wd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_period <= '0;
         r_count  <= '0;
         r_phase  <= 1'b0;
      end else begin
         if (w_wr_period) begin
            r_period <= writedata[PERIOD_W-1:0];
         end
         if (w_wr_period || !w_active) begin
            r_count <= '0;
            r_phase <= 1'b0;
         end else if (w_toggle) begin
            r_count <= '0;
            r_phase <= w_terminal ? 1'b0 : ~r_phase;
         end else begin
            r_count <= r_count + L_P_ONE;
         end
      end
   end

   // Software writes to BLINK_MASK / BURST override the burst engine; done-set overrides its clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask  <= '0;
         r_burst <= 8'd0;
         r_done  <= 1'b0;
      end else begin
         if (w_wr_mask) begin
            r_mask <= w_wd;
         end else if (w_terminal) begin
            r_mask <= '0;
         end
         if (w_wr_burst) begin
            r_burst <= writedata[7:0];
         end else if (w_toggle && (r_burst != 8'd0)) begin
            r_burst <= r_burst - 8'd1;
         end
         if (w_terminal) begin
            r_done <= 1'b1;
         end else if (w_wr_burst || (w_wr_status && writedata[1])) begin
            r_done <= 1'b0;
         end
      end
   end

`ifdef SYSTEM_ALARM_OUT_PIO_IRQ_EN
   logic r_irq_mask;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= 1'b0;
      end else if (w_wr && (address == A_IRQMASK)) begin
         r_irq_mask <= writedata[0];
      end
   end

   assign irq = r_done & r_irq_mask;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rdata = 32'd0;
      case (address)
         A_DATA:    w_rdata = 32'(r_data);
         A_PERIOD:  w_rdata = 32'(r_period);
         A_MASK:    w_rdata = 32'(r_mask);
         A_STATUS:  w_rdata = {16'd0, r_burst, 6'd0, r_done, r_phase};
         A_BURST:   w_rdata = {24'd0, r_burst};
`ifdef SYSTEM_ALARM_OUT_PIO_IRQ_EN
         A_IRQMASK: w_rdata = {31'd0, r_irq_mask};
`endif
         default:   w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'd0;
         out_port <= L_RESET;
      end else begin
         readdata <= w_rdata;
         out_port <= (r_data & ~r_mask) | (r_data & r_mask & {WIDTH{r_phase}});
      end
   end

endmodule

// File: tb/tb_system_alarm_out_pio.sv
// tb/tb_system_alarm_out_pio.sv - randomized self-checking bench for system_alarm_out_pio
module tb_system_alarm_out_pio;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [2:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic [W-1:0] out_port;
   logic         irq;

   int total = 0;
   int bad   = 0;

   system_alarm_out_pio #(.WIDTH(W), .RESET_VALUE(0), .PERIOD_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Returns at the falling edge right after the rising edge that performed the write.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   function automatic logic [W-1:0] blend(input logic [W-1:0] d, input logic [W-1:0] m, input int ph);
      return (d & ~m) | ((ph != 0) ? (d & m) : '0);
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
      repeat (3) @(negedge clk);
      total++; if (out_port !== 5'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", out_port); end
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h exp=0", readdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      reset_n = 1'b1;
      bus_read(3'd0, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd); end
      bus_read(3'd3, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", rd); end
   endtask

   task automatic test_data_ops();
      logic [31:0] rd;
      logic [W-1:0] m_data;
      bus_write(3'd0, 32'h15);
      bus_write(3'd4, 32'h02);
      bus_write(3'd5, 32'h04);
      @(negedge clk);
      total++; if (out_port !== 5'b10011) begin bad++; $display("FAIL data_plan_out got=%b exp=10011", out_port); end
      bus_read(3'd0, rd);
      total++; if (rd !== 32'h13) begin bad++; $display("FAIL data_plan_rd got=%h exp=13", rd); end
      bus_read(3'd4, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL outset_reads_zero got=%h exp=0", rd); end
      m_data = 5'b10011;
      for (int i = 0; i < 16; i++) begin
         int unsigned op;
         logic [31:0] wd;
         op = $urandom_range(0, 2);
         wd = $urandom;
         case (op)
            0: begin m_data = wd[W-1:0];           bus_write(3'd0, wd); end
            1: begin m_data = m_data | wd[W-1:0];  bus_write(3'd4, wd); end
            default: begin m_data = m_data & ~wd[W-1:0]; bus_write(3'd5, wd); end
         endcase
         @(negedge clk);
         total++; if (out_port !== m_data) begin bad++; $display("FAIL data_rand_out i=%0d op=%0d got=%h exp=%h", i, op, out_port, m_data); end
         bus_read(3'd0, rd);
         total++; if (rd !== 32'(m_data)) begin bad++; $display("FAIL data_rand_rd i=%0d got=%h exp=%h", i, rd, m_data); end
      end
   endtask

   // Free-running blink: phase level k covers cycles [k*p, (k+1)*p) after activation.
   task automatic run_free(input logic [W-1:0] d, input int p, input logic [W-1:0] m);
      bus_write(3'd0, 32'(d));
      bus_write(3'd1, 32'(p));
      bus_write(3'd6, 32'd0);
      bus_write(3'd2, 32'(m));
      address = 3'd3;
      for (int n = 1; n <= 4 * p + 3; n++) begin
         int ph;
         @(negedge clk);
         ph = ((n - 1) / p) % 2;
         total++; if (out_port !== blend(d, m, ph)) begin bad++; $display("FAIL free_out p=%0d n=%0d got=%h exp=%h", p, n, out_port, blend(d, m, ph)); end
         total++; if (readdata !== 32'(ph)) begin bad++; $display("FAIL free_status p=%0d n=%0d got=%h exp=%h", p, n, readdata, ph); end
      end
      bus_write(3'd2, 32'd0);
      bus_write(3'd1, 32'd0);
   endtask

   task automatic test_blink_free();
      run_free(5'h1F, 4, 5'b00001);
      for (int i = 0; i < 2; i++) begin
         run_free(5'($urandom), $urandom_range(1, 6), 5'($urandom_range(1, 31)));
      end
   endtask

   task automatic run_burst(input logic [W-1:0] d, input int p, input logic [W-1:0] m, input int b);
      logic [31:0] rd;
      logic [31:0] exp_st;
      bus_write(3'd0, 32'(d));
      bus_write(3'd1, 32'(p));
`ifdef SYSTEM_ALARM_OUT_PIO_IRQ_EN
      bus_write(3'd7, 32'd1);
`endif
      bus_write(3'd6, 32'(b));
      bus_write(3'd2, 32'(m));
      address = 3'd3;
      for (int n = 1; n <= b * p + 2 * p + 2; n++) begin
         int k, ph, cnt, dn;
         logic [W-1:0] mk;
         logic exp_irq;
         @(negedge clk);
         k = n - 1;
         if (k < b * p) begin
            ph = (k / p) % 2; cnt = b - k / p; dn = 0; mk = m;
         end else begin
            ph = 0; cnt = 0; dn = 1; mk = '0;
         end
         exp_st = {16'd0, 8'(cnt), 6'd0, 1'(dn), 1'(ph)};
         total++; if (out_port !== blend(d, mk, ph)) begin bad++; $display("FAIL burst_out p=%0d b=%0d n=%0d got=%h exp=%h", p, b, n, out_port, blend(d, mk, ph)); end
         total++; if (readdata !== exp_st) begin bad++; $display("FAIL burst_status p=%0d b=%0d n=%0d got=%h exp=%h", p, b, n, readdata, exp_st); end
`ifdef SYSTEM_ALARM_OUT_PIO_IRQ_EN
         exp_irq = (n >= b * p);
`else
         exp_irq = 1'b0;
`endif
         total++; if (irq !== exp_irq) begin bad++; $display("FAIL burst_irq n=%0d got=%b exp=%b", n, irq, exp_irq); end
      end
      bus_read(3'd2, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL burst_mask_cleared got=%h exp=0", rd); end
      bus_read(3'd3, rd);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL burst_done_status got=%h exp=2", rd); end
      bus_write(3'd3, 32'h2);
      bus_read(3'd3, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL burst_w1c got=%h exp=0", rd); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL burst_irq_cleared got=%b exp=0", irq); end
`ifdef SYSTEM_ALARM_OUT_PIO_IRQ_EN
      bus_write(3'd7, 32'd0);
`endif
      bus_write(3'd1, 32'd0);
   endtask

   task automatic test_burst();
      run_burst(5'h1F, 3, 5'b00011, 4);
      for (int i = 0; i < 2; i++) begin
         run_burst(5'($urandom), $urandom_range(1, 5), 5'($urandom_range(1, 31)), $urandom_range(1, 5));
      end
   endtask

   task automatic test_period_rewrite();
      bus_write(3'd0, 32'h1F);
      bus_write(3'd1, 32'd8);
      bus_write(3'd6, 32'd0);
      bus_write(3'd2, 32'd1);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      bus_write(3'd1, 32'd2);
      address = 3'd3;
      for (int n = 1; n <= 12; n++) begin
         int ph;
         @(negedge clk);
         ph = ((n - 1) / 2) % 2;
         total++; if (out_port !== blend(5'h1F, 5'h01, ph)) begin bad++; $display("FAIL rewrite_out n=%0d got=%h exp=%h", n, out_port, blend(5'h1F, 5'h01, ph)); end
         total++; if (readdata[0] !== 1'(ph)) begin bad++; $display("FAIL rewrite_phase n=%0d got=%b exp=%0d", n, readdata[0], ph); end
      end
      bus_write(3'd2, 32'd0);
      bus_write(3'd1, 32'd0);
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd;
      bus_write(3'd0, 32'h1F);
      bus_write(3'd1, 32'd3);
      bus_write(3'd6, 32'd5);
      bus_write(3'd2, 32'd3);
      repeat (7) @(negedge clk);
      bus_read(3'd3, rd);
      total++; if (rd[15:8] !== 8'd3) begin bad++; $display("FAIL midrst_pre_cnt got=%0d exp=3", rd[15:8]); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (out_port !== 5'd0) begin bad++; $display("FAIL midrst_out got=%h exp=0", out_port); end
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL midrst_rd got=%h exp=0", readdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", irq); end
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(3'd2, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL midrst_mask got=%h exp=0", rd); end
      address = 3'd3;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         total++; if (out_port !== 5'd0 || readdata !== 32'd0) begin bad++; $display("FAIL midrst_quiet n=%0d out=%h status=%h exp=0/0", n, out_port, readdata); end
      end
   endtask

   initial begin
      test_reset();
      test_data_ops();
      test_blink_free();
      test_burst();
      test_period_rewrite();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
